// File: rtl/wr_ctrl_s.sv
// ============================================================================
// Module   : wr_ctrl_s
// Purpose  : SRAM ring-buffer write controller; fills banks in rotation and
//            waits on full banks until the reader releases them.
// Options  : define WR_CTRL_STALL_CNT_EN to enable the stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wr_ctrl_s #(
  parameter int SRAM_ADDRWIDTH = 9,
  parameter int CYC_BITWIDTH   = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [3:0]                SRAM_num,
  input  logic [3:0]                Data_num,
  input  logic [CYC_BITWIDTH-1:0]   cyc_num,
  input  logic                      IFGB_val,
  output logic                      GBIF_rdy,
  input  logic                      rd_release,
  input  logic [3:0]                rd_release_ID,
  output logic                      write_en,
  output logic [SRAM_ADDRWIDTH-1:0] addr_Wr,
  output logic [3:0]                Wr_ID,
  output logic [3:0]                next_Wr_ID,
  output logic [1:0]                State_Wr,
  output logic [15:0]               bank_full,
  output logic                      wr_bank_done,
  output logic [3:0]                wr_bank_done_ID,
  output logic                      write_SRAM_done,
  output logic [15:0]               wr_stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nx;
  logic [3:0]                r_num;
  logic [3:0]                r_data_num;
  logic [CYC_BITWIDTH-1:0]   r_cyc;
  logic [CYC_BITWIDTH-1:0]   r_fill_cnt;
  logic [CYC_BITWIDTH-1:0]   w_fill_inc;
  logic [SRAM_ADDRWIDTH-1:0] w_last_addr;
  logic [3:0]                w_num_eff;
  logic                      w_last;
  logic                      w_rel_ok;
  logic                      w_target_free;

  function automatic logic [3:0] wrap_inc(input logic [3:0] id, input logic [3:0] num);
    logic [3:0] eff;
    eff = (num == 4'd0) ? 4'd1 : num;
    return (id >= eff - 4'd1) ? 4'd0 : id + 4'd1;
  endfunction

  // (Data_num+1)*2^(AW-4) - 1 is simply Data_num followed by AW-4 ones
  assign w_last_addr   = {r_data_num, {(SRAM_ADDRWIDTH-4){1'b1}}};
  assign w_num_eff     = (r_num == 4'd0) ? 4'd1 : r_num;
  assign w_fill_inc    = r_fill_cnt + {{(CYC_BITWIDTH-1){1'b0}}, 1'b1};
  assign GBIF_rdy      = (r_state == S_WRITE);
  assign write_en      = IFGB_val & GBIF_rdy;
  assign w_last        = write_en && (addr_Wr == w_last_addr);
  assign w_rel_ok      = rd_release && (rd_release_ID < w_num_eff);
  assign w_target_free = !bank_full[Wr_ID] || (w_rel_ok && (rd_release_ID == Wr_ID));
  assign State_Wr      = r_state;
  assign write_SRAM_done = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  w_state_nx = r_state;
      S_WAIT:  if (w_target_free) w_state_nx = S_WRITE;
      S_WRITE: if (w_last) w_state_nx = (w_fill_inc == r_cyc) ? S_DONE : S_WAIT;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    // start restarts the pass from any state
    if (start) w_state_nx = (cyc_num != '0) ? S_WAIT : S_DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_num           <= 4'd0;
      r_data_num      <= 4'd0;
      r_cyc           <= '0;
      r_fill_cnt      <= '0;
      addr_Wr         <= '0;
      Wr_ID           <= 4'd0;
      next_Wr_ID      <= 4'd1;
      bank_full       <= 16'd0;
      wr_bank_done    <= 1'b0;
      wr_bank_done_ID <= 4'd0;
    end else begin
      wr_bank_done <= 1'b0;
      if (start) begin
        r_num      <= SRAM_num;
        r_data_num <= Data_num;
        r_cyc      <= cyc_num;
        r_fill_cnt <= '0;
        addr_Wr    <= '0;
        Wr_ID      <= 4'd0;
        next_Wr_ID <= wrap_inc(4'd0, SRAM_num);
        bank_full  <= 16'd0;
      end else begin
        if (w_rel_ok) bank_full[rd_release_ID] <= 1'b0;
        if (write_en) begin
          if (w_last) begin
            // placed after the release so a same-bank set wins
            bank_full[Wr_ID] <= 1'b1;
            wr_bank_done     <= 1'b1;
            wr_bank_done_ID  <= Wr_ID;
            addr_Wr          <= '0;
            r_fill_cnt       <= w_fill_inc;
            if (w_fill_inc != r_cyc) begin
              Wr_ID      <= next_Wr_ID;
              next_Wr_ID <= wrap_inc(next_Wr_ID, r_num);
            end
          end else begin
            addr_Wr <= addr_Wr + {{(SRAM_ADDRWIDTH-1){1'b0}}, 1'b1};
          end
        end
      end
    end
  end

`ifdef WR_CTRL_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst || start)
      r_stall_cnt <= 16'd0;
    else if ((r_state == S_WAIT) && bank_full[Wr_ID] && (r_stall_cnt != 16'hFFFF))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign wr_stall_cnt = r_stall_cnt;
`else
  assign wr_stall_cnt = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wr_ctrl_s.sv
// ============================================================================
// Module   : tb_wr_ctrl_s
// Purpose  : Self-checking bench for wr_ctrl_s against a bank/word-count model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wr_ctrl_s;

  localparam int AW = 9;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    SRAM_num = 4'd0;
  logic [3:0]    Data_num = 4'd0;
  logic [CW-1:0] cyc_num = '0;
  logic          IFGB_val = 1'b0;
  logic          GBIF_rdy;
  logic          rd_release = 1'b0;
  logic [3:0]    rd_release_ID = 4'd0;
  logic          write_en;
  logic [AW-1:0] addr_Wr;
  logic [3:0]    Wr_ID, next_Wr_ID;
  logic [1:0]    State_Wr;
  logic [15:0]   bank_full;
  logic          wr_bank_done;
  logic [3:0]    wr_bank_done_ID;
  logic          write_SRAM_done;
  logic [15:0]   wr_stall_cnt;

  wr_ctrl_s #(.SRAM_ADDRWIDTH(AW), .CYC_BITWIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .SRAM_num(SRAM_num), .Data_num(Data_num),
    .cyc_num(cyc_num), .IFGB_val(IFGB_val), .GBIF_rdy(GBIF_rdy),
    .rd_release(rd_release), .rd_release_ID(rd_release_ID), .write_en(write_en),
    .addr_Wr(addr_Wr), .Wr_ID(Wr_ID), .next_Wr_ID(next_Wr_ID), .State_Wr(State_Wr),
    .bank_full(bank_full), .wr_bank_done(wr_bank_done), .wr_bank_done_ID(wr_bank_done_ID),
    .write_SRAM_done(write_SRAM_done), .wr_stall_cnt(wr_stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: pass described as fills of m_len words over banks fill%num
  int          m_num = 1;
  int          m_len = 32;
  int          m_cyc = 0;
  int          m_fill = 0;
  int          m_words = 0;
  logic [15:0] m_full = 16'd0;
  bit          active = 1'b0;
  int          writes = 0;
  int          bd_count = 0;
  bit          sram_seen = 1'b0;
  int          exp_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock cycle: check combinational outputs, advance model, check registered outputs
  task automatic cyc();
    int  bank;
    int  set_id;
    bit  nb_done;
    int  nb_id;
    bit  nsram;
    #1;
    chk("gbif_rdy", GBIF_rdy, (State_Wr == 2'd2));
    chk("write_en", write_en, IFGB_val & (State_Wr == 2'd2));
    if (active) chk("next_id", next_Wr_ID, 32'((int'(Wr_ID) + 1) % m_num));
    set_id = -1; nb_done = 0; nb_id = 0; nsram = 0;
    if (start) begin
      m_num = (SRAM_num == 4'd0) ? 1 : int'(SRAM_num);
      m_len = (int'(Data_num) + 1) << (AW - 4);
      m_cyc = int'(cyc_num);
      m_fill = 0; m_words = 0; m_full = 16'd0; active = 1'b1;
      nsram = (cyc_num == '0);
    end else begin
      if (write_en) begin
        bank = m_fill % m_num;
        chk("wr_id", Wr_ID, bank);
        chk("wr_addr", addr_Wr, m_words);
        chk("wr_bank_free", m_full[bank], 0);
        writes++;
        m_words++;
        if (m_words == m_len) begin
          m_full[bank] = 1'b1;
          set_id = bank; nb_done = 1; nb_id = bank;
          m_fill++; m_words = 0;
          nsram = (m_fill == m_cyc);
        end
      end
      if (rd_release && (int'(rd_release_ID) < m_num) && (int'(rd_release_ID) != set_id))
        m_full[rd_release_ID] = 1'b0;
    end
    @(posedge clk); #1;
    chk("bank_full", bank_full, m_full);
    chk("bank_done", wr_bank_done, nb_done);
    if (nb_done) chk("bank_done_id", wr_bank_done_ID, nb_id);
    chk("sram_done", write_SRAM_done, nsram);
    if (write_SRAM_done) sram_seen = 1'b1;
    if (wr_bank_done) bd_count++;
  endtask

  task automatic do_start(input int num, input int dn, input int cy);
    start = 1'b1; SRAM_num = 4'(num); Data_num = 4'(dn); cyc_num = CW'(cy);
    writes = 0; bd_count = 0; sram_seen = 1'b0;
    cyc();
    start = 1'b0;
  endtask

  // val_mode: 0 always valid, 1 toggling, 2 random; rel_mode: 0 none, 1 random
  task automatic run_pass(input int val_mode, input int rel_mode, input int budget);
    for (int i = 0; i < budget && !sram_seen; i++) begin
      case (val_mode)
        0:       IFGB_val = 1'b1;
        1:       IFGB_val = ~IFGB_val;
        default: IFGB_val = 1'($urandom_range(0, 1));
      endcase
      rd_release    = (rel_mode != 0) && ($urandom_range(0, 3) == 0);
      rd_release_ID = 4'($urandom_range(0, 5));
      cyc();
    end
    rd_release = 1'b0;
    chk("pass_finished", sram_seen, 1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_state", State_Wr, 0);
    chk("rst_rdy", GBIF_rdy, 0);
    chk("rst_wen", write_en, 0);
    chk("rst_addr", addr_Wr, 0);
    chk("rst_wr_id", Wr_ID, 0);
    chk("rst_next_id", next_Wr_ID, 1);
    chk("rst_bank_full", bank_full, 0);
    chk("rst_bank_done", wr_bank_done, 0);
    chk("rst_sram_done", write_SRAM_done, 0);
    chk("rst_stall", wr_stall_cnt, 0);
  endtask

  initial begin
    // reset with valid data and a release pending
    IFGB_val = 1'b1; rd_release = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst = 1'b0; rd_release = 1'b0;
    m_full = 16'd0; m_num = 1; active = 1'b0;

    // two banks, one fill each, continuous data
    do_start(2, 0, 2);
    run_pass(0, 0, 200);
    chk("p1_writes", writes, 64);
    chk("p1_bank_dones", bd_count, 2);
    cyc();
    chk("p1_idle", State_Wr, 0);

    // three fills on two banks: stall on bank 0 until released
    do_start(2, 0, 3);
    IFGB_val = 1'b1;
    for (int i = 0; i < 200 && m_fill < 2; i++) cyc();
    chk("p2_reached_64", writes, 64);
    for (int i = 0; i < 17; i++) begin
      chk("p2_wait", State_Wr, 1);
      chk("p2_wait_id", Wr_ID, 0);
      rd_release    = (i == 5);
      rd_release_ID = (i == 5) ? 4'd3 : 4'd0;
      cyc();
    end
    rd_release = 1'b1; rd_release_ID = 4'd0;
    chk("p2_wait_last", State_Wr, 1);
    cyc();
    rd_release = 1'b0;
    chk("p2_resume", State_Wr, 2);
`ifdef WR_CTRL_STALL_CNT_EN
    exp_stall = 18;
`else
    exp_stall = 0;
`endif
    chk("p2_stall_cnt", wr_stall_cnt, exp_stall);
    run_pass(0, 0, 200);
    chk("p2_writes", writes, 96);

    // toggling valid, 64-word fill
    IFGB_val = 1'b0;
    do_start(1, 1, 1);
    chk("p3_stall_cleared", wr_stall_cnt, 0);
    run_pass(1, 0, 400);
    chk("p3_writes", writes, 64);

    // zero fills
    IFGB_val = 1'b1;
    do_start(3, 0, 0);
    chk("p4_done_state", State_Wr, 3);
    cyc();
    chk("p4_writes", writes, 0);
    chk("p4_idle", State_Wr, 0);

    // restart at word 10 of bank 1
    do_start(2, 0, 2);
    for (int i = 0; i < 200 && !(m_fill == 1 && m_words == 10); i++) cyc();
    chk("p5_at_word10", m_words, 10);
    do_start(2, 0, 2);
    chk("p5_wr_id", Wr_ID, 0);
    chk("p5_addr", addr_Wr, 0);
    chk("p5_bank_full", bank_full, 0);
    chk("p5_state", State_Wr, 1);
    run_pass(0, 0, 200);
    chk("p5_writes", writes, 64);

    // reset with start in the middle of a write
    do_start(2, 0, 2);
    for (int i = 0; i < 40; i++) cyc();
    rst = 1'b1; start = 1'b1; rd_release = 1'b1; rd_release_ID = 4'd0;
    @(posedge clk); #1;
    chk_reset_outputs();
    rst = 1'b0; start = 1'b0; rd_release = 1'b0;
    m_full = 16'd0; m_num = 1; active = 1'b0;

    // randomized passes with random valid and random releases
    for (int p = 0; p < 6; p++) begin
      do_start($urandom_range(0, 4), $urandom_range(0, 1), $urandom_range(1, 6));
      run_pass(2, 1, 4000);
      chk("rand_writes", writes, m_cyc * m_len);
      chk("rand_bank_dones", bd_count, m_cyc);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wr_ctrl_s.md
WR_CTRL_S -- requirements
Module: wr_ctrl_s

Interface
REQ-001 Parameter SRAM_ADDRWIDTH, default 9, bank address width.
REQ-002 Parameter CYC_BITWIDTH, default 12, width of fill-count configuration.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle pulse; samples configuration, begins a write pass.
REQ-006 SRAM_num  input  4  number of banks in ring; 0 treated as 1.
REQ-007 Data_num  input  4  fill length code; words per bank fill = (Data_num+1)*2^(SRAM_ADDRWIDTH-4).
REQ-008 cyc_num  input  CYC_BITWIDTH  total bank fills per pass.
REQ-009 IFGB_val  input  1  upstream word valid.
REQ-010 GBIF_rdy  output  1  controller accepts word.
REQ-011 rd_release  input  1  reader frees a bank (pulse).
REQ-012 rd_release_ID  input  4  bank coordinate ID freed.
REQ-013 write_en  output  1  SRAM write strobe.
REQ-014 addr_Wr  output  SRAM_ADDRWIDTH  SRAM write address.
REQ-015 Wr_ID, next_Wr_ID  output  4 each  current / following bank coordinate ID.
REQ-016 State_Wr  output  2  FSM state code.
REQ-017 bank_full  output  16  per-bank filled flag.
REQ-018 wr_bank_done  output  1  pulse: bank fill completed; wr_bank_done_ID output 4.
REQ-019 write_SRAM_done  output  1  pulse: pass complete.
REQ-020 wr_stall_cnt  output  16  cycles stalled on full bank.

Function
REQ-021 FSM SHALL be IDLE=0, WAIT=1, WRITE=2, DONE=3, output on State_Wr.
REQ-022 IDLE -> start: latch config, Wr_ID=0, addr=0, fill counter=0; go WAIT if cyc_num!=0, else DONE.
REQ-023 WAIT -> WRITE next cycle when bank_full[Wr_ID]==0 (including release arriving this cycle).
REQ-024 GBIF_rdy SHALL be 1 only in WRITE; write_en = IFGB_val & GBIF_rdy combinationally, zero latency.
REQ-025 Each accepted word SHALL increment addr_Wr; last word of fill: set bank_full[Wr_ID], pulse wr_bank_done next cycle with completed ID, addr_Wr=0, fill counter +1.
REQ-026 After last word: if fill counter reaches cyc_num go DONE; else Wr_ID advances to next_Wr_ID and FSM goes WAIT.
REQ-027 next_Wr_ID = Wr_ID+1, wrapping to 0 when Wr_ID = SRAM_num-1.
REQ-028 DONE SHALL pulse write_SRAM_done for exactly one cycle, then IDLE.
REQ-029 rd_release clears bank_full[rd_release_ID]; release of non-full bank or ID>=SRAM_num ignored.
REQ-030 Set and release on same bank same cycle: set wins.
REQ-031 start while not IDLE SHALL abort and restart as REQ-022 with bank_full cleared.
REQ-032 IFGB_val outside WRITE SHALL produce no write and no state change.

Reset
REQ-033 rst SHALL force IDLE; GBIF_rdy, write_en, addr_Wr, Wr_ID, bank_full, wr_bank_done, write_SRAM_done, wr_stall_cnt = 0; next_Wr_ID = 1.
REQ-034 rst SHALL take priority over start and rd_release in the same cycle.

Configuration
REQ-035 Macro WR_CTRL_STALL_CNT_EN defined: wr_stall_cnt increments (saturating at 0xFFFF) each cycle in WAIT with target bank full, cleared on start.
REQ-036 Macro undefined: wr_stall_cnt tied to 0, counter logic absent.

Verification
REQ-037 SRAM_num=2, Data_num=0, cyc_num=2, IFGB_val=1 continuously -> 32 writes addr 0..31 bank 0, 32 writes bank 1, two wr_bank_done (IDs 0,1), write_SRAM_done one cycle after 64th word.
REQ-038 SRAM_num=2, cyc_num=3, no release -> stall in WAIT at Wr_ID=0 after 64 words; rd_release ID 0 -> WRITE next cycle; wr_stall_cnt equals stalled cycles (macro on), 0 (macro off).
REQ-039 IFGB_val toggled 1/0 each cycle, Data_num=1 -> 64 writes, addr contiguous, no skipped addresses.
REQ-040 cyc_num=0 -> DONE, write_SRAM_done pulse, zero writes.
REQ-041 start at word 10 of bank 1 -> next cycle Wr_ID=0, addr_Wr=0, bank_full=0.
REQ-042 rst asserted mid-WRITE with start same cycle -> all outputs per REQ-033, FSM IDLE.
